// File: rtl/decode_cycle_pkg.sv
// Shared decode definitions for the decode stage.
//   - opcode constants of the supported instruction subset
//   - ALUControl encodings
//   - immediate-format selector enum
//   - packed control bundle produced by the decoder
package decode_cycle_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       result_src;
    logic [2:0] alu_ctrl;
    imm_t       imm_sel;
  } ctrl_t;

  // ALU op for arithmetic instructions, chosen by funct3. sub_ok is only
  // set for R-type, so an I-ALU immediate with bit 30 set stays an add.
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       sub_ok);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub_ok ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_cycle_regfile.sv
// register_file: NREG x XLEN register file.
//   clk, rst    : clock, synchronous active-high reset (clears every entry)
//   we, wa, wd  : synchronous write port; writes to x0 are dropped
//   ra, rd      : NRP combinational read ports (packed per port)
// A read of x0 returns 0; a read that hits the address being written this
// cycle returns the write data (write-through bypass).
module register_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [4:0]                wa,
  input  logic [XLEN-1:0]           wd,
  input  logic [NRP-1:0][4:0]       ra,
  output logic [NRP-1:0][XLEN-1:0]  rd
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;

  // Out-of-range indices (NREG < 32) are treated like x0.
  assign wr_ok = we && (wa != 5'd0) && (int'(wa) < NREG);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    always_comb begin
      rd[p] = '0;
      if (ra[p] == 5'd0 || int'(ra[p]) >= NREG) rd[p] = '0;
      else if (wr_ok && ra[p] == wa)            rd[p] = wd;
      else                                      rd[p] = regs[ra[p]];
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: decode stage plus the D->E pipeline registers.
//   clk, rst                      : clock, synchronous active-high reset
//   InstrD, PCD, PCPlus4D         : instruction in decode and its PCs
//   RegWriteW, RDW, ResultW       : write-back port into the register file
//   FlushE                        : load a bubble (all zeros) into E
//   *E outputs                    : registered control, operands, indices
// Decoder and immediate extender are combinational; the register file is
// the register_file sub-module. E registers load every cycle (no stall).
module decode_cycle
  import decode_cycle_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic            ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] Imm_Ext_E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RS1_E,
  output logic [4:0]      RS2_E,
  output logic [4:0]      RD_E
);

  ctrl_t                 ctrl;
  logic [XLEN-1:0]       imm;
  logic [1:0][4:0]       ra;
  logic [1:0][XLEN-1:0]  rdata;

  // ---------------- control decoder ----------------
  always_comb begin
    ctrl = '0;
    case (InstrD[6:0])
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 1'b1;
        ctrl.alu_ctrl   = ALU_ADD;
        ctrl.imm_sel    = IMM_I;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.imm_sel   = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct3(InstrD[14:12], InstrD[30]);
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = alu_from_funct3(InstrD[14:12], 1'b0);
        ctrl.imm_sel   = IMM_I;
      end
      OP_BEQ: begin
        ctrl.branch   = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        ctrl.imm_sel  = IMM_B;
      end
      default: ctrl = '0;
    endcase
  end

  // ---------------- immediate extender ----------------
  always_comb begin
    imm = '0;
    case (ctrl.imm_sel)
      IMM_I:   imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S:   imm = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   imm = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                      InstrD[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

  // ---------------- register file ----------------
  assign ra[0] = InstrD[19:15];
  assign ra[1] = InstrD[24:20];

  register_file #(.XLEN(XLEN), .NREG(NREG), .NRP(2)) u_rf (
    .clk (clk),
    .rst (rst),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW),
    .ra  (ra),
    .rd  (rdata)
  );

  // ---------------- D -> E registers ----------------
  // Flush only bubbles the E registers; the write-back above still lands.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 1'b0;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RS1_E       <= '0;
      RS2_E       <= '0;
      RD_E        <= '0;
    end else begin
      RegWriteE   <= ctrl.reg_write;
      MemWriteE   <= ctrl.mem_write;
      BranchE     <= ctrl.branch;
      ALUSrcE     <= ctrl.alu_src;
      ResultSrcE  <= ctrl.result_src;
      ALUControlE <= ctrl.alu_ctrl;
      RD1_E       <= rdata[0];
      RD2_E       <= rdata[1];
      Imm_Ext_E   <= imm;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RS1_E       <= InstrD[19:15];
      RS2_E       <= InstrD[24:20];
      RD_E        <= InstrD[11:7];
    end
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL have these parameters: XLEN, default 32, datapath width; NREG, default 32, register count.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- InstrD  in  32  instruction in decode.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  write-back enable from the write stage.
- RDW  in  5  write-back destination register.
- ResultW  in  32  write-back data, the output of the write-stage result mux.
- FlushE  in  1  insert a bubble into the E registers.
- RegWriteE, MemWriteE, BranchE, ALUSrcE, ResultSrcE  out  1 each  registered control signals.
- ALUControlE  out  3  registered ALU operation.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  32 each  registered operands.
- RS1_E, RS2_E, RD_E  out  5 each  registered register indices.

Function
REQ-003 The decode logic SHALL be combinational on opcode InstrD[6:0]:
- lw 0000011: RegWrite=1, ALUSrc=1, ResultSrc=1, Imm=I.
- sw 0100011: MemWrite=1, ALUSrc=1, Imm=S.
- R-type 0110011: RegWrite=1.
- I-ALU 0010011: RegWrite=1, ALUSrc=1, Imm=I.
- beq 1100011: Branch=1, Imm=B.
- Any other opcode SHALL decode to all-zero control, so it behaves as a NOP.
REQ-004 ALUControl SHALL be:
- 000 add: lw, sw, and add/addi.
- 001 sub: sub (funct7[5]=1 and R-type) and beq.
- 101 slt: funct3=010.
- 011 or: funct3=110.
- 010 and: funct3=111.
- Any other funct3 SHALL decode to 000.
REQ-005 The immediate SHALL be sign-extended to 32 bits:
- I = {Instr[31:20]}.
- S = {Instr[31:25], Instr[11:7]}.
- B = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}.
- Other opcodes SHALL produce 0.
REQ-006 The register file SHALL have 2 combinational read ports, addressed by Instr[19:15] and Instr[24:20], and 1 synchronous write port.
REQ-007 A write SHALL occur at the rising edge when RegWriteW=1 and RDW!=0; a write to x0 SHALL be ignored.
REQ-008 A read of x0 SHALL return 0.
REQ-009 Write-through bypass: when a read address equals RDW, RegWriteW=1 and RDW!=0 in the same cycle, the read SHALL return ResultW.
REQ-010 All E outputs SHALL be registered, with 1-cycle latency from the D inputs; RD_E = Instr[11:7], RS1_E = Instr[19:15], RS2_E = Instr[24:20].
REQ-011 FlushE=1 SHALL load 0 into every E register at the next edge; the register-file write in that cycle SHALL still occur.
REQ-012 The block SHALL contain no stall input; the E registers SHALL load every cycle.

Reset
REQ-013 When rst=1 at a rising edge, every E output SHALL become 0 and all NREG registers SHALL become 0.
REQ-014 rst SHALL take priority over FlushE and over a concurrent write-back; a write presented in the reset cycle SHALL be discarded.
REQ-015 One cycle after rst deasserts, the block SHALL operate normally, with no extra latency.

Structure
REQ-016 A shared package SHALL hold:
- The opcode constants.
- The ALUControl encodings.
- The immediate-type enum (I/S/B/NONE).
REQ-017 The register file SHALL be a sub-module named register_file, containing the ports, the write gating and the bypass of REQ-006..009 and the reset of REQ-013.
REQ-018 The control decoder and the immediate extender SHALL be combinational logic inside decode_cycle.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write then read: RegWriteW=1, RDW=5, ResultW=0xDEADBEEF; next cycle InstrD=add x1,x5,x0 -> RD1_E=0xDEADBEEF one cycle later.
- Bypass: in the same cycle, RegWriteW=1, RDW=3, ResultW=0x12345678 and InstrD=sub x4,x3,x3 -> RD1_E=RD2_E=0x12345678, ALUControlE=001.
- x0 protection: RegWriteW=1, RDW=0, ResultW=0xFFFFFFFF; then read x0 -> RD1_E=0, including the bypass cycle.
- Immediates:
  - lw with imm -4 -> Imm_Ext_E=0xFFFFFFFC, ALUSrcE=1, ResultSrcE=1.
  - sw with imm 8 -> Imm_Ext_E=0x00000008, MemWriteE=1.
  - beq with offset -16 -> Imm_Ext_E=0xFFFFFFF0, BranchE=1.
- Flush and reset:
  - FlushE=1 with a valid lw -> all E outputs 0 next cycle, while a concurrent write to x7 lands.
  - rst=1 after writing x7=0x55 -> x7 reads 0 and E outputs are 0.
